// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI register responder.
// Command byte layout: [7:3] register address, [1] direction (1 = write), [2] and [0] ignored.
package spi_resp_pkg;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 8;
  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_DIR_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain for one asynchronous input plus single-cycle rise/fall strobes
// derived from the synchronized level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values;
  // blocking = here would collapse the chain into a single stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= w_q;
    end
  end

  assign w_q    = r_sync[STAGES-1];
  assign o_rise = w_q & ~r_prev;
  assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a register file to an SPI master and a fabric host port.
// Define SPI_AUTOINC_EN to advance the frame address after every completed data byte.
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int STATUS_ADDR = 25,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_SCLK,
  input  logic              spi_MOSI,
  input  logic              spi_SS_n,
  output logic              spi_MISO,
  output logic              spi_MISO_oe,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_active
);

  state_t r_state, w_next_state;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [DATA_W-2:0]      r_rx_shift;  // the eighth bit is the live MOSI sample
  logic [DATA_W-1:0]      r_tx_shift;
  logic [2:0]             r_bit_cnt;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_dir;
  logic [DATA_W-1:0]      r_regs [NUM_REGS];

  logic              w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic              w_mosi, w_last_bit, w_spi_we, w_addr_ok, w_host_ok;
  logic [DATA_W-1:0] w_rx_byte, w_rd_data, w_tx_next;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .i_clk (clk_clk),
    .i_rst (reset_reset),
    .i_d   (spi_SCLK),
    .o_rise(w_sclk_rise),
    .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .i_clk (clk_clk),
    .i_rst (reset_reset),
    .i_d   (spi_SS_n),
    .o_rise(w_ss_rise),
    .o_fall(w_ss_fall)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_mosi_sync <= '0;
    else             r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_MOSI};
  end

  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_byte  = {r_rx_shift, w_mosi};
  assign w_last_bit = w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_addr_ok  = int'(r_addr) < NUM_REGS;
  assign w_host_ok  = int'(host_addr) < NUM_REGS;
  assign w_spi_we   = (r_state == DATA) && r_dir && w_last_bit && !w_ss_rise;
  assign w_rd_data  = w_addr_ok ? r_regs[r_addr] : '0;
  assign w_tx_next  = ((r_state == DATA) && !r_dir) ? w_rd_data : '0;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= IDLE;
    else             r_state <= w_next_state;
  end

  // NOTE: always_comb assigns a default before any branch so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_next_state = CMD;
      CMD:     if (w_ss_rise) w_next_state = IDLE;
               else if (w_last_bit) w_next_state = DATA;
      DATA:    if (w_ss_rise) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    spi_MISO_oe  = 1'b0;
    frame_active = 1'b0;
    spi_MISO     = 1'b0;
    if (r_state != IDLE) begin
      spi_MISO_oe  = 1'b1;
      frame_active = 1'b1;
      spi_MISO     = r_tx_shift[DATA_W-1];
    end
  end

  // Shift datapath; a deselect mid-byte simply drops the partial byte.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_bit_cnt  <= '0;
      r_addr     <= '0;
      r_dir      <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_ss_fall) begin
        r_tx_shift <= r_regs[STATUS_ADDR];
        r_bit_cnt  <= '0;
      end
    end else if (w_ss_rise) begin
      r_tx_shift <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_sclk_rise) begin
        r_rx_shift <= w_rx_byte[DATA_W-2:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          if (r_state == CMD) begin
            r_addr <= w_rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
            r_dir  <= w_rx_byte[CMD_DIR_BIT];
          end
`ifdef SPI_AUTOINC_EN
          else begin
            r_addr <= r_addr + 5'd1;
          end
`endif
        end
      end
      if (w_sclk_fall) begin
        if (r_bit_cnt == 3'd0) r_tx_shift <= w_tx_next;
        else                   r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  // NOTE: the register file is reset element by element because its cleared state is
  // architecturally visible; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      host_rdata <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      // SPI commit takes priority over a same-cycle host write to the same register.
      if (host_we && w_host_ok && !(w_spi_we && (host_addr == r_addr)))
        r_regs[host_addr] <= host_wdata;
      if (w_spi_we && w_addr_ok)
        r_regs[r_addr] <= w_rx_byte;
      host_rdata <= w_host_ok ? r_regs[host_addr] : '0;
      wr_valid   <= w_spi_we;
      if (w_spi_we) begin
        wr_addr <= r_addr;
        wr_data <= w_rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: table of SPI frames plus abort, collision and
// reset-mid-frame sequences. Expected values follow SPI_AUTOINC_EN when it is defined.
module tb_spi_reg_responder;

  localparam int SYNC = 2;
  localparam int HALF = 80;  // SCLK half period = 8 system clocks
`ifdef SPI_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       spi_SCLK = 1'b0, spi_MOSI = 1'b0, spi_SS_n = 1'b1;
  logic       spi_MISO, spi_MISO_oe, frame_active, wr_valid;
  logic       host_we = 1'b0;
  logic [4:0] host_addr = '0, wr_addr;
  logic [7:0] host_wdata = '0, host_rdata, wr_data;

  int tests = 0;
  int fails = 0;
  int wr_pulses = 0;
  logic [4:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  spi_reg_responder #(.NUM_REGS(32), .STATUS_ADDR(25), .SYNC_STAGES(SYNC)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .spi_SCLK    (spi_SCLK),
    .spi_MOSI    (spi_MOSI),
    .spi_SS_n    (spi_SS_n),
    .spi_MISO    (spi_MISO),
    .spi_MISO_oe (spi_MISO_oe),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_active(frame_active)
  );

  always #5 clk_clk = ~clk_clk;

  always @(negedge clk_clk) begin
    if (wr_valid) begin
      wr_pulses = wr_pulses + 1;
      last_wa   = wr_addr;
      last_wd   = wr_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    #10;
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [4:0] a, output logic [7:0] d);
    host_addr = a;
    #20;
    d = host_rdata;
  endtask

  task automatic ss_low();
    spi_MOSI = 1'b0; spi_SS_n = 1'b0;
    #(HALF);
  endtask

  task automatic ss_high();
    #(HALF);
    spi_SS_n = 1'b1;
    #(2*HALF);
  endtask

  // Master-side mode-0 shifter; optionally fires a host write aligned to the commit cycle
  // of the last bit (commit edge lands SYNC cycles + 5 after the SCLK rise).
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit col,
                          input logic [4:0] ca, input logic [7:0] cd, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_MOSI = tx[7-i];
      #(HALF);
      spi_SCLK = 1'b1;
      rx = {rx[6:0], spi_MISO};
      if (col && i == nbits-1) begin
        #(10*SYNC);
        host_addr = ca; host_wdata = cd; host_we = 1'b1;
        #10;
        host_we = 1'b0;
        #(HALF - 10*SYNC - 10);
      end else begin
        #(HALF);
      end
      spi_SCLK = 1'b0;
    end
  endtask

  typedef struct {
    string      name;
    int         pw_n;
    logic [4:0] pw_a0; logic [7:0] pw_d0;
    logic [4:0] pw_a1; logic [7:0] pw_d1;
    logic [7:0] cmd;
    int         n;
    logic [7:0] d0, d1;
    logic [7:0] e_stat, e0, e1;
    int         e_wr;
    logic [4:0] e_wa; logic [7:0] e_wd;
    logic [4:0] chk_a; logic [7:0] chk_d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] stat, r0, r1, rd, dummy;
    int w0;

    vecs[0] = '{"status",      1, 5'd25, 8'hA5, 5'd0,  8'h00, 8'h18, 1, 8'h00, 8'h00,
                8'hA5, 8'h00, 8'h00, 0, 5'd0, 8'h00, 5'd25, 8'hA5};
    vecs[1] = '{"spi_write",   0, 5'd0,  8'h00, 5'd0,  8'h00, 8'h52, 1, 8'h3C, 8'h00,
                8'hA5, 8'h00, 8'h00, 1, 5'd10, 8'h3C, 5'd10, 8'h3C};
    vecs[2] = '{"cmd_only",    1, 5'd8,  8'h22, 5'd0,  8'h00, 8'h42, 0, 8'h00, 8'h00,
                8'hA5, 8'h00, 8'h00, 0, 5'd0, 8'h00, 5'd8, 8'h22};
    vecs[3] = '{"multi_read",  1, 5'd7,  8'h11, 5'd0,  8'h00, 8'h3D, 2, 8'h00, 8'h00,
                8'hA5, 8'h11, AI ? 8'h22 : 8'h11, 0, 5'd0, 8'h00, 5'd7, 8'h11};
    vecs[4] = '{"wrap_read",   2, 5'd31, 8'h77, 5'd0,  8'h5A, 8'hF8, 2, 8'h00, 8'h00,
                8'hA5, 8'h77, AI ? 8'h5A : 8'h77, 0, 5'd0, 8'h00, 5'd31, 8'h77};
    vecs[5] = '{"multi_write", 0, 5'd0,  8'h00, 5'd0,  8'h00, 8'h2F, 2, 8'h81, 8'h42,
                8'hA5, 8'h00, 8'h00, 2, AI ? 5'd6 : 5'd5, 8'h42, AI ? 5'd6 : 5'd5, 8'h42};

    #30;
    reset_reset = 1'b0;
    #20;
    check("rst_miso", spi_MISO, 1'b0);
    check("rst_oe", spi_MISO_oe, 1'b0);
    check("rst_frame_active", frame_active, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    host_read(5'd25, rd);
    check("rst_reg25", rd, 8'h00);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pw_n > 0) host_write(vecs[v].pw_a0, vecs[v].pw_d0);
      if (vecs[v].pw_n > 1) host_write(vecs[v].pw_a1, vecs[v].pw_d1);
      w0 = wr_pulses;
      r0 = '0; r1 = '0;
      ss_low();
      spi_bits(vecs[v].cmd, 8, 1'b0, 5'd0, 8'h00, stat);
      if (vecs[v].n > 0) spi_bits(vecs[v].d0, 8, 1'b0, 5'd0, 8'h00, r0);
      if (vecs[v].n > 1) spi_bits(vecs[v].d1, 8, 1'b0, 5'd0, 8'h00, r1);
      ss_high();
      check({vecs[v].name, "_status"}, stat, vecs[v].e_stat);
      if (vecs[v].n > 0) check({vecs[v].name, "_byte0"}, r0, vecs[v].e0);
      if (vecs[v].n > 1) check({vecs[v].name, "_byte1"}, r1, vecs[v].e1);
      check({vecs[v].name, "_wr_count"}, wr_pulses - w0, vecs[v].e_wr);
      if (vecs[v].e_wr > 0) begin
        check({vecs[v].name, "_wr_addr"}, last_wa, vecs[v].e_wa);
        check({vecs[v].name, "_wr_data"}, last_wd, vecs[v].e_wd);
      end
      host_read(vecs[v].chk_a, rd);
      check({vecs[v].name, "_reg"}, rd, vecs[v].chk_d);
    end

    // Abort: deselect after 5 bits of a write data byte to addr 12.
    w0 = wr_pulses;
    ss_low();
    check("abort_oe_selected", spi_MISO_oe, 1'b1);
    check("abort_active_selected", frame_active, 1'b1);
    spi_bits(8'h62, 8, 1'b0, 5'd0, 8'h00, dummy);
    spi_bits(8'hFF, 5, 1'b0, 5'd0, 8'h00, dummy);
    ss_high();
    check("abort_wr_count", wr_pulses - w0, 0);
    check("abort_oe", spi_MISO_oe, 1'b0);
    check("abort_miso", spi_MISO, 1'b0);
    check("abort_frame_active", frame_active, 1'b0);
    host_read(5'd12, rd);
    check("abort_reg12", rd, 8'h00);

    // Collision, same address: SPI 0x55 beats host 0x99 on reg 4.
    w0 = wr_pulses;
    ss_low();
    spi_bits(8'h22, 8, 1'b0, 5'd0, 8'h00, dummy);
    spi_bits(8'h55, 8, 1'b1, 5'd4, 8'h99, dummy);
    ss_high();
    check("collide_wr_count", wr_pulses - w0, 1);
    host_read(5'd4, rd);
    check("collide_same_reg4", rd, 8'h55);

    // Collision, different addresses: both land.
    ss_low();
    spi_bits(8'h22, 8, 1'b0, 5'd0, 8'h00, dummy);
    spi_bits(8'h66, 8, 1'b1, 5'd9, 8'h99, dummy);
    ss_high();
    host_read(5'd4, rd);
    check("collide_diff_reg4", rd, 8'h66);
    host_read(5'd9, rd);
    check("collide_diff_reg9", rd, 8'h99);

    // Reset mid-frame during a write to addr 3; reset also clears the register file.
    w0 = wr_pulses;
    ss_low();
    spi_bits(8'h1A, 8, 1'b0, 5'd0, 8'h00, dummy);
    spi_bits(8'hC3, 4, 1'b0, 5'd0, 8'h00, dummy);
    reset_reset = 1'b1;
    #30;
    check("midrst_miso", spi_MISO, 1'b0);
    check("midrst_oe", spi_MISO_oe, 1'b0);
    check("midrst_frame_active", frame_active, 1'b0);
    spi_SS_n = 1'b1;
    #30;
    reset_reset = 1'b0;
    #40;
    check("midrst_wr_count", wr_pulses - w0, 0);
    host_read(5'd3, rd);
    check("midrst_reg3", rd, 8'h00);

    w0 = wr_pulses;
    ss_low();
    spi_bits(8'h1A, 8, 1'b0, 5'd0, 8'h00, stat);
    spi_bits(8'h96, 8, 1'b0, 5'd0, 8'h00, dummy);
    ss_high();
    check("postrst_status", stat, 8'h00);
    check("postrst_wr_count", wr_pulses - w0, 1);
    check("postrst_wr_addr", last_wa, 5'd3);
    check("postrst_wr_data", last_wd, 8'h96);
    host_read(5'd3, rd);
    check("postrst_reg3", rd, 8'h96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI slave (responder) for the spi0 master interface; the MAX3421E-style command/register protocol seen from the peripheral side.
- Holds a 32x8 register file that the SPI master reads and writes.
- Fabric logic shares the register file through a host port.
- Used as an on-chip USB-controller stand-in and as a loopback target for spi0 bring-up.

Parameters:
- NUM_REGS, 32, register file depth; the address width is fixed at 5.
- STATUS_ADDR, 25, register returned on MISO during the command byte.
- SYNC_STAGES, 2, synchronizer depth on SCLK/MOSI/SS_n; legal values 2-3.

Ports:
- clk_clk  in  1  system clock; SCLK must be at most clk_clk/8.
- reset_reset  in  1  synchronous, active-high reset.
- spi_SCLK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_MOSI  in  1  master-out data, MSB first.
- spi_SS_n  in  1  active-low slave select.
- spi_MISO  out  1  slave-out data.
- spi_MISO_oe  out  1  MISO output enable; 1 while selected.
- host_we  in  1  fabric write strobe.
- host_addr  in  5  fabric register address.
- host_wdata  in  8  fabric write data.
- host_rdata  out  8  registered read data at host_addr; 1-cycle latency.
- wr_valid  out  1  1-cycle pulse when an SPI write byte commits.
- wr_addr  out  5  address of the committed SPI write.
- wr_data  out  8  data of the committed SPI write.
- frame_active  out  1  high while in CMD or DATA.

Behaviour:
- Reset:
  - All outputs 0, all registers 0, state IDLE, bit counter 0, synchronizers cleared.
  - Reset asserted mid-frame aborts the frame with no commit.
- Input sync and edge detect:
  - SCLK, MOSI and SS_n each pass through SYNC_STAGES flops.
  - Rise and fall strobes are derived from the synchronized SCLK.
  - All protocol actions occur on these strobes.
- States:
  - IDLE -> CMD on synced SS_n falling. On entry, load tx_shift with reg[STATUS_ADDR], clear the bit counter and set spi_MISO_oe=1.
  - CMD -> DATA on the 8th rise. The command byte is cmd[7:3]=addr, cmd[1]=dir (1=write), with cmd[2] and cmd[0] ignored. Latch addr and dir.
  - DATA stays in DATA for any number of bytes.
  - Any state -> IDLE on synced SS_n rising. The partial byte is discarded with no commit; MISO and oe go to 0.
- Shifting:
  - On rise: rx_shift <= {rx_shift[6:0], MOSI}; bit counter increments mod 8.
  - On fall: if the bit counter is 0 (byte boundary), load the next tx byte; otherwise tx_shift <= tx_shift<<1.
  - The next tx byte is reg[addr] in DATA when dir=0, and 0x00 when dir=1.
  - spi_MISO = tx_shift[7] while selected, else 0.
- Write commit:
  - On the 8th rise of each DATA byte with dir=1, write reg[addr] <= rx byte.
  - On the following clk_clk, pulse wr_valid with wr_addr/wr_data.
- Read sampling: read data is sampled at the load instant on fall, so a host write landing before that fall is visible.
- Address:
  - Fixed for the whole frame (FIFO-style) unless SPI_AUTOINC_EN is defined.
  - Addresses >= NUM_REGS read as 0x00 and writes to them are dropped, but wr_valid still pulses.
- Collisions:
  - An SPI commit and host_we to the same address in the same cycle: the SPI commit wins.
  - Different addresses: both writes take effect.
- host_rdata reflects the register file including same-cycle SPI commits one cycle later.
- A frame with only the command byte is legal: status is shifted out, no writes occur.

Optional Feature:
- Macro SPI_AUTOINC_EN.
- When defined, the frame address increments after every completed DATA byte (read or write), wrapping 31->0.
  - For reads, the increment occurs before the next byte is loaded.
- When undefined, the address stays at the command address for the entire frame.

Decomposition:
- Package spi_resp_pkg:
  - typedef state_t {IDLE, CMD, DATA}.
  - Constants ADDR_W=5, DATA_W=8.
  - Command field positions CMD_ADDR_MSB=7, CMD_ADDR_LSB=3, CMD_DIR_BIT=1.
- One sub-module: spi_sync_edge, the synchronizer chain plus rise/fall strobe generation, instantiated for SCLK and SS_n (MOSI uses the sync output only).

Test Plan:
- Reset mid-frame:
  - Stimulus: assert reset after 4 SCLK of a write frame to addr 3.
  - Response: outputs 0, reg[3] unchanged, no wr_valid, a subsequent frame decodes normally.
- Status readback:
  - Stimulus: host writes reg[25]=0xA5, then the master sends cmd 0x18 (read addr 3).
  - Response: MISO returns 0xA5 during the command byte.
- SPI write:
  - Stimulus: cmd 0x52 (write addr 10), data 0x3C, SS_n high.
  - Response: reg[10]=0x3C, a single wr_valid with wr_addr=10, wr_data=0x3C; host_rdata=0x3C at addr 10.
- Multi-byte read:
  - Stimulus: reg[7]=0x11, reg[8]=0x22, cmd 0x38 followed by 2 bytes.
  - Response: 0x11,0x11 without the macro; 0x11,0x22 with SPI_AUTOINC_EN. Also with the macro, a read from addr 31 then wraps to reg[0].
- Abort:
  - Stimulus: SS_n rises after 5 bits of a write data byte.
  - Response: no commit, no wr_valid, MISO/oe=0, state IDLE.
- Collision:
  - Stimulus: host_we to addr 4 (0x99) in the same cycle as an SPI commit of 0x55 to addr 4.
  - Response: reg[4]=0x55.
